// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// seg_scan_driver_if : glyph-word load port and 4-digit display drive lines
// Revision 1.0
// ============================================================================
interface seg_scan_driver_if;
   logic        load;
   logic [19:0] word_in;
   logic [3:0]  dp_in;
   logic [3:0]  blink_en;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   modport master (
      output load, word_in, dp_in, blink_en,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  load, word_in, dp_in, blink_en,
      output an, seg, dp, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// seg_scan_driver : latches 4 glyph codes and scans a common-anode 7-seg display
// Revision 1.0
// ============================================================================
module seg_scan_driver #(
   parameter int SCAN_DIV  = 50000,
   parameter int GUARD     = 16,
   parameter int BLINK_DIV = 128
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   seg_scan_driver_if.slave bus
);
   localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int            FW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_DIV - 1);
   localparam logic [31:0]   GUARD_LEN = GUARD;

   function automatic logic [6:0] glyph(input logic [4:0] code);
      logic [6:0] pat;
      case (code)
         5'd0:    pat = 7'h3F;
         5'd1:    pat = 7'h06;
         5'd2:    pat = 7'h5B;
         5'd3:    pat = 7'h4F;
         5'd4:    pat = 7'h66;
         5'd5:    pat = 7'h6D;
         5'd6:    pat = 7'h7D;
         5'd7:    pat = 7'h07;
         5'd8:    pat = 7'h7F;
         5'd9:    pat = 7'h6F;
         5'd10:   pat = 7'h77;
         5'd11:   pat = 7'h7C;
         5'd12:   pat = 7'h39;
         5'd13:   pat = 7'h5E;
         5'd14:   pat = 7'h79;
         5'd15:   pat = 7'h71;
         5'd16:   pat = 7'h76;
         5'd17:   pat = 7'h1E;
         5'd18:   pat = 7'h38;
         5'd19:   pat = 7'h54;
         5'd20:   pat = 7'h73;
         5'd21:   pat = 7'h50;
         5'd22:   pat = 7'h78;
         5'd23:   pat = 7'h3E;
         5'd24:   pat = 7'h5C;
         5'd25:   pat = 7'h40;
         default: pat = 7'h00;
      endcase
      return pat;
   endfunction

   logic [CW-1:0]  cnt;
   logic [1:0]     idx;
   logic [FW-1:0]  frm;
   logic           phase_on;

   logic [19:0]    stage_word;
   logic [3:0]     stage_dp;
   logic [3:0]     stage_blink;
   logic           pending;

   logic [3:0][4:0] shadow_code;
   logic [3:0]     shadow_dp;
   logic [3:0]     shadow_blink;

   logic           slot_end;
   logic           frame_end;
   logic           in_guard;
   logic           blanked;
   logic [6:0]     lit;

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == 2'd0);
   assign in_guard  = (32'(cnt) < GUARD_LEN);
   assign lit       = glyph(shadow_code[idx]);
   assign blanked   = shadow_blink[idx] && !phase_on;

   // Outputs are registered from the current slot state, so they trail the counter by one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt            <= '0;
         idx            <= 2'd3;
         frm            <= '0;
         phase_on       <= 1'b1;
         stage_word     <= '1;
         stage_dp       <= '0;
         stage_blink    <= '0;
         pending        <= 1'b0;
         shadow_code    <= '1;
         shadow_dp      <= '0;
         shadow_blink   <= '0;
         bus.an         <= 4'hF;
         bus.seg        <= 7'h7F;
         bus.dp         <= 1'b1;
         bus.frame_done <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end)
            idx <= idx - 2'd1;

         if (frame_end) begin
            if (frm == FRM_LAST) begin
               frm      <= '0;
               phase_on <= ~phase_on;
            end else begin
               frm <= frm + 1'b1;
            end
            if (pending) begin
               shadow_code  <= stage_word;
               shadow_dp    <= stage_dp;
               shadow_blink <= stage_blink;
            end
         end

         // A load on the boundary edge stays pending; the shadow takes the older staging value.
         if (bus.load) begin
            stage_word  <= bus.word_in;
            stage_dp    <= bus.dp_in;
            stage_blink <= bus.blink_en;
            pending     <= 1'b1;
         end else if (frame_end) begin
            pending <= 1'b0;
         end

         bus.an         <= in_guard ? 4'hF : ~(4'b0001 << idx);
         bus.seg        <= blanked ? 7'h7F : ~lit;
         bus.dp         <= blanked ? 1'b1 : ~shadow_dp[idx];
         bus.frame_done <= frame_end;
      end
   end
endmodule
`default_nettype wire
